// File: rtl/fifo_rd_drain_pkg.sv
// fifo_rd_drain_pkg: read-side types and constants shared by fifo_rd_drain
// and its skid buffer.
//   rd_state_e : consumer FSM states (guard wait, streaming, flush/discard)
//   SKID_DEPTH : number of words the output skid buffer can hold
package fifo_rd_drain_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } rd_state_e;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_drain_skid_buf2.sv
// skid_buf2: 2-entry register buffer feeding a valid/ready output stream.
//   rd_clk, rd_rstb : clock, async active-low reset
//   push, din       : write din behind the current contents
//   pop             : drop the head entry
//   clear           : discard all entries (wins over push/pop)
//   occ             : number of valid entries (0..2)
//   head            : registered head entry
module skid_buf2
    import fifo_rd_drain_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              rd_clk,
    input  logic              rd_rstb,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DWIDTH-1:0] din,
    output logic [1:0]        occ,
    output logic [DWIDTH-1:0] head
);

    logic [DWIDTH-1:0] ent1;

    always_ff @(posedge rd_clk or negedge rd_rstb) begin
        if (!rd_rstb) begin
            occ  <= 2'd0;
            head <= '0;
            ent1 <= '0;
        end else if (clear) begin
            // Data registers keep stale contents; occ alone marks them invalid.
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= din;
                    else             ent1 <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= ent1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged: second entry advances, new word fills in behind.
                    if (occ == 2'(SKID_DEPTH)) begin
                        head <= ent1;
                        ent1 <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-domain consumer for the async FIFO. Issues rd_en
// against fifo_empty, captures rd_data into a 2-entry skid buffer and
// presents it on a registered valid/ready stream.
//   rd_clk, rd_rstb        : read clock, async active-low reset
//   fifo_empty, rd_data    : FIFO read side (rd_data valid with rd_en & ~fifo_empty)
//   rd_en                  : FIFO read strobe (combinational)
//   flush                  : discard buffered and FIFO-resident words
//   out_valid/ready/data   : output stream
//   rd_count               : words delivered, wraps modulo 2^CWIDTH
//   busy_flush             : high while discarding
module fifo_rd_drain
    import fifo_rd_drain_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 16,
    parameter int GUARD  = 3
) (
    input  logic              rd_clk,
    input  logic              rd_rstb,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] rd_data,
    output logic              rd_en,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [CWIDTH-1:0] rd_count,
    output logic              busy_flush
);

    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

    rd_state_e   state;
    logic [GW-1:0] guard_cnt;
    logic [1:0]  occ;
    logic        push;
    logic        pop;
    logic        clear;

    // out_ready never reaches rd_en: a full buffer blocks reads even if it
    // is being drained this cycle.
    always_comb begin
        rd_en = 1'b0;
        case (state)
            ST_RUN:   rd_en = ~fifo_empty & (occ < 2'(SKID_DEPTH)) & ~flush;
            ST_FLUSH: rd_en = ~fifo_empty;
            default:  rd_en = 1'b0;
        endcase
    end

    assign push       = rd_en & (state == ST_RUN);   // FLUSH reads are dropped
    assign pop        = out_valid & out_ready;
    assign clear      = (state == ST_RUN) & flush;
    assign out_valid  = (occ != 2'd0);
    assign busy_flush = (state == ST_FLUSH);

    skid_buf2 #(.DWIDTH(DWIDTH)) u_skid (
        .rd_clk  (rd_clk),
        .rd_rstb (rd_rstb),
        .push    (push),
        .pop     (pop),
        .clear   (clear),
        .din     (rd_data),
        .occ     (occ),
        .head    (out_data)
    );

    always_ff @(posedge rd_clk or negedge rd_rstb) begin
        if (!rd_rstb) begin
            state     <= ST_WAIT;
            guard_cnt <= '0;
            rd_count  <= '0;
        end else begin
            // A handshake in the flush-request cycle still counts.
            if (pop) rd_count <= rd_count + CWIDTH'(1);
            case (state)
                ST_WAIT: begin
                    guard_cnt <= guard_cnt + 1'b1;
                    if (guard_cnt == GW'(GUARD - 1)) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (flush) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (fifo_empty & ~flush) state <= ST_RUN;
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
module tb_fifo_rd_drain;

    localparam int DWIDTH = 8;
    localparam int CWIDTH = 4;
    localparam int GUARD  = 3;

    logic              rd_clk;
    logic              rd_rstb;
    logic              fifo_empty;
    logic [DWIDTH-1:0] rd_data;
    logic              rd_en;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;
    logic [CWIDTH-1:0] rd_count;
    logic              busy_flush;

    fifo_rd_drain #(.DWIDTH(DWIDTH), .CWIDTH(CWIDTH), .GUARD(GUARD)) dut (
        .rd_clk     (rd_clk),
        .rd_rstb    (rd_rstb),
        .fifo_empty (fifo_empty),
        .rd_data    (rd_data),
        .rd_en      (rd_en),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .rd_count   (rd_count),
        .busy_flush (busy_flush)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    int n_vec = 0;
    int n_err = 0;
    int nreads = 0;
    int ndeliv = 0;
    bit sb_on = 1'b1;

    logic [DWIDTH-1:0] fifo_q[$];
    logic [DWIDTH-1:0] exp_q[$];

    logic              s_rd, s_emp, s_ov, s_bf;
    logic [DWIDTH-1:0] s_od;
    logic [CWIDTH-1:0] s_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic fifo_upd();
        fifo_empty = (fifo_q.size() == 0);
        rd_data    = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic fifo_push(input logic [DWIDTH-1:0] w);
        fifo_q.push_back(w);
        fifo_upd();
    endtask

    // One clock cycle: sample mid-cycle, score the handshake, model the FIFO
    // pop, then let the edge happen and refresh the FIFO outputs.
    task automatic step();
        logic [DWIDTH-1:0] w;
        @(negedge rd_clk);
        s_rd = rd_en; s_emp = fifo_empty; s_ov = out_valid;
        s_od = out_data; s_cnt = rd_count; s_bf = busy_flush;
        if (s_ov && out_ready) begin
            ndeliv++;
            if (exp_q.size() == 0) chk("sb_unexpected", {24'd0, s_od}, 32'hFFFF_FFFF);
            else                   chk("sb_data", {24'd0, s_od}, {24'd0, exp_q.pop_front()});
        end
        if (s_rd && !s_emp) begin
            w = fifo_q.pop_front();
            nreads++;
            if (sb_on) exp_q.push_back(w);
        end
        @(posedge rd_clk);
        #1;
        fifo_upd();
    endtask

    task automatic drain(input string tag, input int maxc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (fifo_q.size() == 0 && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic guard_check(input string tag);
        for (int k = 0; k <= GUARD; k++) begin
            step();
            chk(tag, {31'd0, s_rd}, {31'd0, (k == GUARD)});
        end
    endtask

    initial begin
        int r0, d0, ov_seen;
        bit fl_done;
        rd_rstb = 1'b0; flush = 1'b0; out_ready = 1'b1;
        fifo_q.delete(); exp_q.delete();
        fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33); fifo_push(8'h44);

        // Reset state with a non-empty FIFO
        repeat (2) @(posedge rd_clk);
        #1;
        chk("rst_rden",  {31'd0, rd_en}, 32'd0);
        chk("rst_vld",   {31'd0, out_valid}, 32'd0);
        chk("rst_data",  {24'd0, out_data}, 32'd0);
        chk("rst_cnt",   {28'd0, rd_count}, 32'd0);
        chk("rst_busy",  {31'd0, busy_flush}, 32'd0);
        rd_rstb = 1'b1;

        // Guard: no read in cycles 0..GUARD-1, first read in cycle GUARD
        guard_check("guard_rden");

        // Streaming: one word per cycle
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stream_vld", {31'd0, s_ov}, 32'd1);
        end
        chk("stream_cnt", {28'd0, rd_count}, 32'd4);
        chk("stream_sb",  exp_q.size(), 32'd0);

        // Backpressure: only two reads while out_ready is low
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) fifo_push(8'hA0 + 8'(k));
        r0 = nreads;
        repeat (6) step();
        chk("bp_reads", nreads - r0, 32'd2);
        chk("bp_rden",  {31'd0, s_rd}, 32'd0);
        chk("bp_vld",   {31'd0, s_ov}, 32'd1);
        chk("bp_hold",  {24'd0, s_od}, 32'hA0);
        out_ready = 1'b1;
        d0 = ndeliv;
        drain("bp_drain", 30);
        chk("bp_deliv", ndeliv - d0, 32'd5);
        chk("bp_cnt",   {28'd0, rd_count}, 32'd9);

        // Simultaneous push and pop at occupancy 1
        fifo_push(8'hC0); fifo_push(8'hC1);
        step();
        chk("pp_first", {30'd0, s_rd, s_ov}, 32'b10);
        step();
        chk("pp_both",  {30'd0, s_rd, s_ov}, 32'b11);
        step();
        chk("pp_occ1",  {30'd0, s_rd, s_ov}, 32'b01);
        chk("pp_cnt",   {28'd0, s_cnt}, 32'd10);
        chk("pp_cnt2",  {28'd0, rd_count}, 32'd11);

        // Flush: two buffered, three in the FIFO
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) fifo_push(8'hB0 + 8'(k));
        step(); step(); step();
        chk("fl_full",  {31'd0, s_rd}, 32'd0);
        flush = 1'b1; out_ready = 1'b1;
        step();                                  // B0 handshaken and scored
        chk("fl_rden",  {31'd0, s_rd}, 32'd0);
        flush = 1'b0;
        exp_q.delete();
        sb_on = 1'b0;
        r0 = nreads; ov_seen = 0; fl_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_ov) ov_seen++;
            if (i == 0) chk("fl_busy", {31'd0, s_bf}, 32'd1);
            if (!s_bf) begin
                fl_done = 1'b1;
                break;
            end
        end
        chk("fl_exit",  {31'd0, fl_done}, 32'd1);
        chk("fl_vld",   ov_seen, 32'd0);
        chk("fl_reads", nreads - r0, 32'd3);
        chk("fl_cnt",   {28'd0, rd_count}, 32'd12);
        sb_on = 1'b1;

        // Mid-stream reset with a full skid buffer
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) fifo_push(8'hD0 + 8'(k));
        step(); step(); step();
        rd_rstb = 1'b0;
        #1;
        chk("mrst_vld",  {31'd0, out_valid}, 32'd0);
        chk("mrst_cnt",  {28'd0, rd_count}, 32'd0);
        chk("mrst_rden", {31'd0, rd_en}, 32'd0);
        chk("mrst_busy", {31'd0, busy_flush}, 32'd0);
        exp_q.delete();
        @(posedge rd_clk);
        #1;
        rd_rstb = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 15; k++) fifo_push(8'h50 + 8'(k));
        guard_check("mrst_guard");

        // Counter wrap: 17 words through a 4-bit counter
        d0 = ndeliv;
        drain("wrap_drain", 60);
        chk("wrap_deliv", ndeliv - d0, 32'd17);
        chk("wrap_cnt",   {28'd0, rd_count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
